// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared graphics types: grid object codes, player states/directions, pixel type
package graphics_pkg;

    // RGB444 pixel.
    typedef logic [11:0] pixel_t;

    // Tile object codes held in the object grid; 11..15 are unassigned.
    typedef enum logic [3:0] {
        G_EMPTY         = 4'd0,
        G_COUNTER       = 4'd1,
        G_ONION_WHOLE   = 4'd2,
        G_ONION_CHOPPED = 4'd3,
        G_POT_EMPTY     = 4'd4,
        G_POT_RAW       = 4'd5,
        G_POT_COOKED    = 4'd6,
        G_PLATE         = 4'd7,
        G_SOUP          = 4'd8,
        G_STOVE         = 4'd9,
        G_EXTINGUISHER  = 4'd10
    } grid_obj_t;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_WALK  = 2'd1,
        P_CARRY = 2'd2,
        P_CHOP  = 2'd3
    } player_state_t;

    typedef enum logic [1:0] {
        P_UP    = 2'd0,
        P_DOWN  = 2'd1,
        P_LEFT  = 2'd2,
        P_RIGHT = 2'd3
    } player_dir_t;

endpackage

// File: rtl/grid_renderer_if.sv
// rtl/grid_renderer_if.sv - video timing in/out bundle between XVGA timing, renderer and VGA output
// Ports (master drives the timing side, slave is the renderer):
//   hcount[10:0], vcount[9:0], hsync, vsync, blank, player_pixel  -> renderer
//   hsync_out, vsync_out, blank_out, pixel_out                    <- renderer
interface grid_renderer_if;
    import graphics_pkg::*;

    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        blank;
    pixel_t      player_pixel;
    logic        hsync_out;
    logic        vsync_out;
    logic        blank_out;
    pixel_t      pixel_out;

    modport master (
        output hcount, vcount, hsync, vsync, blank, player_pixel,
        input  hsync_out, vsync_out, blank_out, pixel_out
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, blank, player_pixel,
        output hsync_out, vsync_out, blank_out, pixel_out
    );

endinterface

// File: rtl/tile_sprite_rom.sv
// rtl/tile_sprite_rom.sv - tile sprite ROM, synchronous read with one cycle of latency
// Ports: clock, reset (async, active-high), addr = {code, local_y, local_x}, data (registered RGB444)
module tile_sprite_rom
    import graphics_pkg::*;
#(
    parameter int     OBJ_W       = 4,
    parameter int     LOG2_TS     = 5,
    parameter pixel_t TRANSPARENT = 12'hF0F,
    parameter int     AW          = OBJ_W + 2 * LOG2_TS
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    output pixel_t        data
);

    logic [OBJ_W-1:0]   code;
    logic [LOG2_TS-1:0] lx;
    logic [LOG2_TS-1:0] ly;
    logic [7:0]         pat;
    pixel_t             data_d;
    pixel_t             data_q;

    // Sprite art is generated from the address: the top-left 8x8 corner is
    // keyed out, the rest carries the object code in the red nibble and a
    // position gradient in green/blue.
    always_comb begin
        {code, ly, lx} = addr;
        pat            = 8'(ly) << 3;
        pat            = pat + 8'(lx);
        if ((lx < LOG2_TS'(8)) && (ly < LOG2_TS'(8))) begin
            data_d = TRANSPARENT;
        end else begin
            data_d = {4'(code), pat};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/grid_renderer.sv
// rtl/grid_renderer.sv - 3-stage kitchen tile-grid renderer with frame-shadowed grids and progress bars
// Ports: clock, reset (async, active-high), vid (grid_renderer_if.slave: timing/player in, pixel/syncs out),
//        object_grid / time_grid [GRID_ROWS][GRID_COLS][OBJ_W] live per-tile object codes and timers
module grid_renderer
    import graphics_pkg::*;
#(
    parameter int     GRID_COLS   = 13,
    parameter int     GRID_ROWS   = 8,
    parameter int     TILE_SIZE   = 32,
    parameter int     ORIGIN_X    = 112,
    parameter int     ORIGIN_Y    = 112,
    parameter int     OBJ_W       = 4,
    parameter int     BAR_H       = 4,
    parameter pixel_t TRANSPARENT = 12'hF0F,
    parameter pixel_t FLOOR_COLOR = 12'h864,
    parameter pixel_t BAR_COLOR   = 12'h0F0,
    parameter pixel_t BAR_BG      = 12'h222
) (
    input  logic                                         clock,
    input  logic                                         reset,
    grid_renderer_if.slave                               vid,
    input  logic [GRID_ROWS-1:0][GRID_COLS-1:0][OBJ_W-1:0] object_grid,
    input  logic [GRID_ROWS-1:0][GRID_COLS-1:0][OBJ_W-1:0] time_grid
);

    localparam int LOG2_TS = $clog2(TILE_SIZE);
    localparam int COL_W   = $clog2(GRID_COLS);
    localparam int ROW_W   = $clog2(GRID_ROWS);
    localparam int FW      = LOG2_TS + 1;
    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + GRID_COLS * TILE_SIZE);
    localparam logic [9:0]  Y_LO = 10'(ORIGIN_Y);
    localparam logic [9:0]  Y_HI = 10'(ORIGIN_Y + GRID_ROWS * TILE_SIZE);
    localparam logic [LOG2_TS-1:0] BAR_Y = LOG2_TS'(TILE_SIZE - BAR_H);

    typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0][OBJ_W-1:0] grid_t;

    // Frame latch
    logic  vs_prev_d, vs_prev_q;
    grid_t shadow_obj_d, shadow_obj_q;
    grid_t shadow_time_d, shadow_time_q;

    // S1: tile map and shadow read
    logic               in_grid1_d, in_grid1_q;
    logic [LOG2_TS-1:0] lx1_d, lx1_q, ly1_d, ly1_q;
    logic [OBJ_W-1:0]   code1_d, code1_q, t1_d, t1_q;
    pixel_t             pp1_d, pp1_q;
    logic               hs1_d, hs1_q, vs1_d, vs1_q, bl1_d, bl1_q;

    // S2: bar decision, aligned with ROM data
    logic   in_grid2_d, in_grid2_q, sprite2_d, sprite2_q;
    logic   bar2_d, bar2_q, fill2_d, fill2_q;
    pixel_t pp2_d, pp2_q;
    logic   hs2_d, hs2_q, vs2_d, vs2_q, bl2_d, bl2_q;

    // Output register
    pixel_t pix_d, pix_q;
    logic   hs3_d, hs3_q, vs3_d, vs3_q, bl3_d, bl3_q;

    logic [10:0]       off_x;
    logic [9:0]        off_y;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              in_grid;
    logic              is_pot;
    logic [FW-1:0]     fill_lim;
    pixel_t            rom_data;

    tile_sprite_rom #(
        .OBJ_W       (OBJ_W),
        .LOG2_TS     (LOG2_TS),
        .TRANSPARENT (TRANSPARENT)
    ) u_rom (
        .clock (clock),
        .reset (reset),
        .addr  ({code1_q, ly1_q, lx1_q}),
        .data  (rom_data)
    );

    always_comb begin
        // Shadows only change on a vsync falling edge, so a frame never tears.
        vs_prev_d     = vid.vsync;
        shadow_obj_d  = shadow_obj_q;
        shadow_time_d = shadow_time_q;
        if (vs_prev_q && !vid.vsync) begin
            shadow_obj_d  = object_grid;
            shadow_time_d = time_grid;
        end

        // Raw hcount/vcount are range-checked first, so the offsets below are
        // only meaningful (and only used for indexing) inside the grid.
        in_grid = (vid.hcount >= X_LO) && (vid.hcount < X_HI) &&
                  (vid.vcount >= Y_LO) && (vid.vcount < Y_HI);
        off_x   = vid.hcount - X_LO;
        off_y   = vid.vcount - Y_LO;
        col     = in_grid ? COL_W'(off_x >> LOG2_TS) : '0;
        row     = in_grid ? ROW_W'(off_y >> LOG2_TS) : '0;

        in_grid1_d = in_grid;
        lx1_d      = LOG2_TS'(off_x);
        ly1_d      = LOG2_TS'(off_y);
        code1_d    = in_grid ? shadow_obj_q[row][col]  : '0;
        t1_d       = in_grid ? shadow_time_q[row][col] : '0;
        pp1_d      = vid.player_pixel;
        hs1_d      = vid.hsync;
        vs1_d      = vid.vsync;
        bl1_d      = vid.blank;

        // Timer t fills t sixteenths of the tile width.
        is_pot     = (code1_q == OBJ_W'(G_POT_RAW)) || (code1_q == OBJ_W'(G_POT_COOKED));
        fill_lim   = FW'(t1_q) << (LOG2_TS - 4);
        in_grid2_d = in_grid1_q;
        sprite2_d  = in_grid1_q && (code1_q != OBJ_W'(G_EMPTY)) &&
                     (code1_q <= OBJ_W'(G_EXTINGUISHER));
        bar2_d     = in_grid1_q && is_pot && (t1_q != '0) && (ly1_q >= BAR_Y);
        fill2_d    = {1'b0, lx1_q} < fill_lim;
        pp2_d      = pp1_q;
        hs2_d      = hs1_q;
        vs2_d      = vs1_q;
        bl2_d      = bl1_q;

        if (bl2_q) begin
            pix_d = '0;
        end else if (pp2_q != '0) begin
            pix_d = pp2_q;
        end else if (bar2_q) begin
            pix_d = fill2_q ? BAR_COLOR : BAR_BG;
        end else if (sprite2_q && (rom_data != TRANSPARENT)) begin
            pix_d = rom_data;
        end else if (in_grid2_q) begin
            pix_d = FLOOR_COLOR;
        end else begin
            pix_d = '0;
        end
        hs3_d = hs2_q;
        vs3_d = vs2_q;
        bl3_d = bl2_q;
    end

    // Sync and blank stages reset to their idle level so nothing glitches
    // out of the pipeline right after reset is released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vs_prev_q     <= 1'b1;
            shadow_obj_q  <= '0;
            shadow_time_q <= '0;
            in_grid1_q    <= 1'b0;
            lx1_q         <= '0;
            ly1_q         <= '0;
            code1_q       <= '0;
            t1_q          <= '0;
            pp1_q         <= '0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            bl1_q         <= 1'b1;
            in_grid2_q    <= 1'b0;
            sprite2_q     <= 1'b0;
            bar2_q        <= 1'b0;
            fill2_q       <= 1'b0;
            pp2_q         <= '0;
            hs2_q         <= 1'b1;
            vs2_q         <= 1'b1;
            bl2_q         <= 1'b1;
            pix_q         <= '0;
            hs3_q         <= 1'b1;
            vs3_q         <= 1'b1;
            bl3_q         <= 1'b1;
        end else begin
            vs_prev_q     <= vs_prev_d;
            shadow_obj_q  <= shadow_obj_d;
            shadow_time_q <= shadow_time_d;
            in_grid1_q    <= in_grid1_d;
            lx1_q         <= lx1_d;
            ly1_q         <= ly1_d;
            code1_q       <= code1_d;
            t1_q          <= t1_d;
            pp1_q         <= pp1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            bl1_q         <= bl1_d;
            in_grid2_q    <= in_grid2_d;
            sprite2_q     <= sprite2_d;
            bar2_q        <= bar2_d;
            fill2_q       <= fill2_d;
            pp2_q         <= pp2_d;
            hs2_q         <= hs2_d;
            vs2_q         <= vs2_d;
            bl2_q         <= bl2_d;
            pix_q         <= pix_d;
            hs3_q         <= hs3_d;
            vs3_q         <= vs3_d;
            bl3_q         <= bl3_d;
        end
    end

    assign vid.pixel_out = pix_q;
    assign vid.hsync_out = hs3_q;
    assign vid.vsync_out = vs3_q;
    assign vid.blank_out = bl3_q;

endmodule
